sd_command_controller: RTL and testbench
========================================

# sd_command_controller

Command sequencer placed behind `SpiReceiver` in the SD-card-over-SPI slave. It takes each decoded command frame (`Command`, `CommandArgument`, `ReadSuccess`) and runs the SD SPI-mode initialisation state: in-idle flag, CMD55 application prefix and ACMD41 polling. For each frame it builds the R1, R3 or R7 response and streams it byte by byte to the SPI transmitter over a valid/ready handshake. For CMD17 it also issues a block-read request to the storage backend.

## Interface
- `INIT_POLLS`, default 2: number of ACMD41 calls answered "still idle" (R1 = 0x01) before initialisation completes.
- `OCR_VDD`, default 24'hFF8000: voltage window returned in OCR bits [23:0].

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `io_ArgumentReadFinished`  in  1  level from receiver; its rising edge marks a complete frame.
- `io_ReadSuccess`  in  1  frame framing valid; sampled with the edge.
- `io_Command`  in  6  command index.
- `io_CommandArgument`  in  32  command argument.
- `io_RespValid`  out  1  `io_RespByte` is valid.
- `io_RespReady`  in  1  transmitter accepts the byte.
- `io_RespByte`  out  8  response byte.
- `io_RespLast`  out  1  current byte is the final byte of the response.
- `io_ReadReq`  out  1  one-cycle pulse on accepted CMD17.
- `io_ReadAddr`  out  32  CMD17 argument, held until the next CMD17.
- `io_InIdle`  out  1  SD in-idle-state flag.
- `io_Dropped`  out  1  one-cycle pulse when a frame arrives while not in WAIT.
- `io___state`  out  3  debug state encoding.

## Operation
- Reset values:
  - `io_InIdle` = 1.
  - `io_RespValid`, `io_RespLast`, `io_ReadReq`, `io_Dropped` = 0.
  - `io_RespByte` = 0xFF, `io_ReadAddr` = 0.
  - State = WAIT, app flag = 0, poll counter = 0.
- States and encodings: WAIT (0), DECODE (1), NCR (2), R1 (3), TAIL (4).
- WAIT:
  - On the rising edge of `io_ArgumentReadFinished`, latch the command, argument and `ReadSuccess`.
  - Go to DECODE.
- DECODE builds the R1 byte. Bit 0 = in-idle, bit 2 = illegal command, bit 3 = CRC/frame error. Then go to NCR.
  - `ReadSuccess` = 0: R1 = {4'b0, 1, 0, 0, idle}; no side effects.
  - CMD0: set idle = 1, clear the poll counter; R1 = 0x01.
  - CMD8: R7 response. Tail bytes are 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: set the app flag; R1 only.
  - ACMD41 (index 41 with app flag = 1): if poll counter < `INIT_POLLS`, increment it and R1 = 0x01. Otherwise clear idle and R1 = 0x00.
  - CMD58: R3 response. Tail = OCR, MSB first: {~idle, ~idle, 6'b0, `OCR_VDD`} (power-up and CCS set once initialised).
  - CMD16: R1 only.
  - CMD17: R1 only. If idle = 0, pulse `io_ReadReq` and load `io_ReadAddr`. If idle = 1, set the illegal bit and do not request.
  - Any other index, or index 41 without the app flag: illegal bit set.
  - The app flag is cleared by every decoded command except CMD55.
- NCR: present 0xFF (the one-byte Ncr gap). On accept, go to R1.
- R1: present the R1 byte. `io_RespLast` = 1 if there is no tail. On accept, go to TAIL or WAIT.
- TAIL: present 4 bytes in order. `io_RespLast` = 1 on the 4th byte. On the final accept, go to WAIT.
- Frames arriving outside WAIT are discarded, with an `io_Dropped` pulse; state is unaffected.

## Timing
- Edge detected in cycle N.
- DECODE runs in N+1; `io_ReadReq` pulses in N+1.
- `io_RespValid` rises in N+2 with 0xFF.
- Handshake:
  - The byte and `io_RespLast` are stable while valid && !ready.
  - Advance happens in the cycle after valid && ready.
  - A ready held high moves one byte per cycle.
- Minimum response length: R1 command = 2 transfers (NCR + R1); R3/R7 = 6 transfers.
- `io_RespValid` drops in the cycle after the last accept; WAIT accepts a new edge in that same cycle.
- Asserting reset mid-response aborts the transfer immediately and restores every reset value, including idle = 1.

## Configuration
- `SD_APP_CMD_EN` defined: CMD55/ACMD41 behave as described.
- Undefined:
  - CMD55 and index 41 are illegal.
  - CMD1 takes the ACMD41 role: same poll counter and `INIT_POLLS` rule.
  - The app flag register is not built.

## Test plan
- Reset, then CMD0 arg 0 with `ReadSuccess` = 1 and ready held high -> bytes 0xFF, 0x01; `io_RespLast` on the 2nd byte; `io_InIdle` = 1.
- CMD8 arg 0x000001AA -> 0xFF, 0x01, 0x00, 0x00, 0x01, 0xAA.
- With `INIT_POLLS` = 2, send CMD55 + ACMD41 three times -> R1 sequence 0x01, 0x01, then 0x00. `io_InIdle` falls after the 3rd ACMD41. A subsequent CMD58 returns 0xFF, 0x00, 0xC0, 0xFF, 0x80, 0x00.
- CMD17 arg 128913 before init -> R1 0x05, no `io_ReadReq`. After init -> R1 0x00; `io_ReadReq` pulses one cycle after the edge with `io_ReadAddr` = 128913.
- Ready low for 5 cycles during the R1 byte -> byte held stable, no skip. A frame edge injected then -> `io_Dropped` pulse, response unchanged.
- Frame with `ReadSuccess` = 0 -> R1 0x09 while idle. Reset asserted mid-TAIL -> valid = 0 at once, idle = 1.

Source files
------------

// File: rtl/sd_command_controller.sv
// SD SPI-mode command sequencer: decodes receiver frames, tracks init state, streams R1/R3/R7 responses.
// Define SD_APP_CMD_EN for CMD55/ACMD41 initialisation; otherwise CMD1 drives initialisation.
module sd_command_controller #(
  parameter int          INIT_POLLS = 2,
  parameter logic [23:0] OCR_VDD    = 24'hFF8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ArgumentReadFinished,
  input  logic        io_ReadSuccess,
  input  logic [5:0]  io_Command,
  input  logic [31:0] io_CommandArgument,
  output logic        io_RespValid,
  input  logic        io_RespReady,
  output logic [7:0]  io_RespByte,
  output logic        io_RespLast,
  output logic        io_ReadReq,
  output logic [31:0] io_ReadAddr,
  output logic        io_InIdle,
  output logic        io_Dropped,
  output logic [2:0]  io___state
);
  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    NCR    = 3'd2,
    R1     = 3'd3,
    TAIL   = 3'd4
  } state_t;

  localparam logic [7:0] POLL_MAX = 8'(INIT_POLLS);

  state_t      state_q, state_d;
  logic        arf_q;
  logic [5:0]  cmd_q, cmd_d;
  logic [11:0] arg_q, arg_d;
  logic        rs_q, rs_d;
  logic        idle_q, idle_d;
  logic [7:0]  polls_q, polls_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] tail_q, tail_d;
  logic        has_tail_q, has_tail_d;
  logic [1:0]  idx_q, idx_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic        rise;
  logic        init_cmd;

  assign rise = io_ArgumentReadFinished & ~arf_q;

`ifdef SD_APP_CMD_EN
  logic app_q, app_d;
  assign init_cmd = (cmd_q == 6'd41) && app_q;
`else
  assign init_cmd = (cmd_q == 6'd1);
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    rs_d         = rs_q;
    idle_d       = idle_q;
    polls_d      = polls_q;
    r1_d         = r1_q;
    tail_d       = tail_q;
    has_tail_d   = has_tail_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    req_d        = 1'b0;
    drop_d       = rise && (state_q != WAIT);
`ifdef SD_APP_CMD_EN
    app_d        = app_q;
`endif
    io_RespValid = 1'b0;
    io_RespByte  = 8'hFF;
    io_RespLast  = 1'b0;
    case (state_q)
      WAIT: begin
        if (rise) begin
          cmd_d   = io_Command;
          arg_d   = io_CommandArgument[11:0];
          rs_d    = io_ReadSuccess;
          state_d = DECODE;
          // Idle only changes in DECODE, so the read request can be issued straight off the edge.
          if (io_ReadSuccess && io_Command == 6'd17 && !idle_q) begin
            req_d  = 1'b1;
            addr_d = io_CommandArgument;
          end
        end
      end
      DECODE: begin
        state_d    = NCR;
        idx_d      = 2'd0;
        has_tail_d = 1'b0;
        tail_d     = 32'h0;
        r1_d       = {7'b0, idle_q};
        if (!rs_q) begin
          r1_d = {4'b0, 1'b1, 2'b0, idle_q};
        end else begin
`ifdef SD_APP_CMD_EN
          app_d = 1'b0;
`endif
          if (init_cmd) begin
            if (polls_q < POLL_MAX) begin
              polls_d = polls_q + 8'd1;
              r1_d    = 8'h01;
            end else begin
              idle_d = 1'b0;
              r1_d   = 8'h00;
            end
          end else begin
            case (cmd_q)
              6'd0: begin
                idle_d  = 1'b1;
                polls_d = 8'd0;
                r1_d    = 8'h01;
              end
              6'd8: begin
                has_tail_d = 1'b1;
                tail_d     = {20'h0, arg_q};
              end
              6'd16: ;
              6'd17: r1_d[2] = idle_q;
              6'd58: begin
                has_tail_d = 1'b1;
                tail_d     = {~idle_q, ~idle_q, 6'b0, OCR_VDD};
              end
`ifdef SD_APP_CMD_EN
              6'd55: app_d = 1'b1;
`endif
              default: r1_d[2] = 1'b1;
            endcase
          end
        end
      end
      NCR: begin
        io_RespValid = 1'b1;
        if (io_RespReady) state_d = R1;
      end
      R1: begin
        io_RespValid = 1'b1;
        io_RespByte  = r1_q;
        io_RespLast  = !has_tail_q;
        if (io_RespReady) state_d = has_tail_q ? TAIL : WAIT;
      end
      TAIL: begin
        io_RespValid = 1'b1;
        io_RespByte  = tail_q[31:24];
        io_RespLast  = (idx_q == 2'd3);
        if (io_RespReady) begin
          tail_d = {tail_q[23:0], 8'h00};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT;
      arf_q      <= 1'b0;
      cmd_q      <= 6'd0;
      arg_q      <= 12'd0;
      rs_q       <= 1'b0;
      idle_q     <= 1'b1;
      polls_q    <= 8'd0;
      r1_q       <= 8'h00;
      tail_q     <= 32'h0;
      has_tail_q <= 1'b0;
      idx_q      <= 2'd0;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      drop_q     <= 1'b0;
`ifdef SD_APP_CMD_EN
      app_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      arf_q      <= io_ArgumentReadFinished;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      rs_q       <= rs_d;
      idle_q     <= idle_d;
      polls_q    <= polls_d;
      r1_q       <= r1_d;
      tail_q     <= tail_d;
      has_tail_q <= has_tail_d;
      idx_q      <= idx_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
`ifdef SD_APP_CMD_EN
      app_q      <= app_d;
`endif
    end
  end

  assign io_ReadReq  = req_q;
  assign io_ReadAddr = addr_q;
  assign io_InIdle   = idle_q;
  assign io_Dropped  = drop_q;
  assign io___state  = state_q;
endmodule

// File: tb/tb_sd_command_controller.sv
// Directed bench for sd_command_controller: init sequence, R1/R3/R7 streams, backpressure, drops, reset abort.
module tb_sd_command_controller;
  logic        clock = 1'b0;
  logic        rst;
  logic        arf;
  logic        rs;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        io_RespValid;
  logic        ready;
  logic [7:0]  io_RespByte;
  logic        io_RespLast;
  logic        io_ReadReq;
  logic [31:0] io_ReadAddr;
  logic        io_InIdle;
  logic        io_Dropped;
  logic [2:0]  io___state;

  int n_cmp = 0;
  int n_err = 0;

  sd_command_controller dut (
    .clock                   (clock),
    .reset                   (rst),
    .io_ArgumentReadFinished (arf),
    .io_ReadSuccess          (rs),
    .io_Command              (cmd),
    .io_CommandArgument      (arg),
    .io_RespValid            (io_RespValid),
    .io_RespReady            (ready),
    .io_RespByte             (io_RespByte),
    .io_RespLast             (io_RespLast),
    .io_ReadReq              (io_ReadReq),
    .io_ReadAddr             (io_ReadAddr),
    .io_InIdle               (io_InIdle),
    .io_Dropped              (io_Dropped),
    .io___state              (io___state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns one cycle after the edge-detect cycle (DUT in DECODE).
  task automatic send_frame(input logic [5:0] c, input logic [31:0] a, input logic s);
    step();
    cmd = c;
    arg = a;
    rs  = s;
    arf = 1'b1;
    step();
    arf = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    while (io_RespValid !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk({tag, " valid"}, {31'b0, io_RespValid}, 32'd1);
  endtask

  // Expected bytes left-aligned in exp, first byte in [47:40].
  task automatic get_resp(input string tag, input int n, input logic [47:0] exp);
    wait_valid(tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte%0d", tag, i), {24'b0, io_RespByte}, {24'b0, exp[47-8*i -: 8]});
      chk($sformatf("%s last%0d", tag, i), {31'b0, io_RespLast}, {31'b0, (i == n - 1)});
      step();
    end
    chk({tag, " done"}, {31'b0, io_RespValid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arf = 1'b0; rs = 1'b0; cmd = 6'd0; arg = 32'h0; ready = 1'b1;
    step(); step();
    chk("rst idle",  {31'b0, io_InIdle},    32'd1);
    chk("rst valid", {31'b0, io_RespValid}, 32'd0);
    chk("rst last",  {31'b0, io_RespLast},  32'd0);
    chk("rst req",   {31'b0, io_ReadReq},   32'd0);
    chk("rst drop",  {31'b0, io_Dropped},   32'd0);
    chk("rst byte",  {24'b0, io_RespByte},  32'hFF);
    chk("rst addr",  io_ReadAddr,           32'h0);
    chk("rst state", {29'b0, io___state},   32'd0);
    rst = 1'b0;

    send_frame(6'd0, 32'h0, 1'b1);
    get_resp("cmd0", 2, {8'hFF, 8'h01, 32'h0});
    chk("cmd0 idle", {31'b0, io_InIdle}, 32'd1);

    send_frame(6'd8, 32'h0000_01AA, 1'b1);
    get_resp("cmd8", 6, {8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA});

    send_frame(6'd17, 32'd128913, 1'b1);
    chk("cmd17 pre req", {31'b0, io_ReadReq}, 32'd0);
    get_resp("cmd17 pre", 2, {8'hFF, 8'h05, 32'h0});

    send_frame(6'd0, 32'h0, 1'b0);
    get_resp("badframe", 2, {8'hFF, 8'h09, 32'h0});
    chk("badframe idle", {31'b0, io_InIdle}, 32'd1);

`ifdef SD_APP_CMD_EN
    send_frame(6'd41, 32'h4000_0000, 1'b1);
    get_resp("acmd41 noapp", 2, {8'hFF, 8'h05, 32'h0});
    send_frame(6'd55, 32'h0, 1'b1);
    get_resp("cmd55 a", 2, {8'hFF, 8'h01, 32'h0});
    send_frame(6'd41, 32'h4000_0000, 1'b1);
    get_resp("acmd41 a", 2, {8'hFF, 8'h01, 32'h0});
    send_frame(6'd55, 32'h0, 1'b1);
    get_resp("cmd55 b", 2, {8'hFF, 8'h01, 32'h0});
    send_frame(6'd41, 32'h4000_0000, 1'b1);
    get_resp("acmd41 b", 2, {8'hFF, 8'h01, 32'h0});
    chk("idle before last", {31'b0, io_InIdle}, 32'd1);
    send_frame(6'd55, 32'h0, 1'b1);
    get_resp("cmd55 c", 2, {8'hFF, 8'h01, 32'h0});
    send_frame(6'd41, 32'h4000_0000, 1'b1);
    get_resp("acmd41 c", 2, {8'hFF, 8'h00, 32'h0});
`else
    send_frame(6'd55, 32'h0, 1'b1);
    get_resp("cmd55 illegal", 2, {8'hFF, 8'h05, 32'h0});
    send_frame(6'd1, 32'h0, 1'b1);
    get_resp("cmd1 a", 2, {8'hFF, 8'h01, 32'h0});
    send_frame(6'd1, 32'h0, 1'b1);
    get_resp("cmd1 b", 2, {8'hFF, 8'h01, 32'h0});
    chk("idle before last", {31'b0, io_InIdle}, 32'd1);
    send_frame(6'd1, 32'h0, 1'b1);
    get_resp("cmd1 c", 2, {8'hFF, 8'h00, 32'h0});
`endif
    chk("init idle", {31'b0, io_InIdle}, 32'd0);

    send_frame(6'd58, 32'h0, 1'b1);
    get_resp("cmd58", 6, {8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00});

    send_frame(6'd17, 32'd128913, 1'b1);
    chk("cmd17 req",  {31'b0, io_ReadReq}, 32'd1);
    chk("cmd17 addr", io_ReadAddr,         32'd128913);
    step();
    chk("cmd17 req pulse", {31'b0, io_ReadReq}, 32'd0);
    get_resp("cmd17 post", 2, {8'hFF, 8'h00, 32'h0});
    chk("cmd17 addr held", io_ReadAddr, 32'd128913);

    ready = 1'b0;
    send_frame(6'd16, 32'd512, 1'b1);
    wait_valid("bp");
    chk("bp ncr", {24'b0, io_RespByte}, 32'hFF);
    ready = 1'b1;
    step();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        cmd = 6'd8; rs = 1'b1; arf = 1'b1;
      end
      step();
      if (k == 1) begin
        chk("drop pulse", {31'b0, io_Dropped}, 32'd1);
        arf = 1'b0;
      end
      if (k == 2) chk("drop once", {31'b0, io_Dropped}, 32'd0);
      chk($sformatf("bp byte%0d", k),  {24'b0, io_RespByte},  32'h00);
      chk($sformatf("bp last%0d", k),  {31'b0, io_RespLast},  32'd1);
      chk($sformatf("bp valid%0d", k), {31'b0, io_RespValid}, 32'd1);
      chk($sformatf("bp state%0d", k), {29'b0, io___state},   32'd3);
    end
    ready = 1'b1;
    step();
    chk("bp done", {31'b0, io_RespValid}, 32'd0);

    send_frame(6'd8, 32'h0000_01AA, 1'b1);
    wait_valid("abort");
    step(); step(); step();
    chk("abort in tail", {29'b0, io___state}, 32'd4);
    chk("abort tail byte", {24'b0, io_RespByte}, 32'h00);
    rst = 1'b1;
    #1;
    chk("abort valid", {31'b0, io_RespValid}, 32'd0);
    chk("abort idle",  {31'b0, io_InIdle},    32'd1);
    chk("abort state", {29'b0, io___state},   32'd0);
    chk("abort byte",  {24'b0, io_RespByte},  32'hFF);
    chk("abort addr",  io_ReadAddr,           32'h0);
    step(); step();
    rst = 1'b0;

    send_frame(6'd16, 32'd512, 1'b1);
    get_resp("post reset cmd16", 2, {8'hFF, 8'h01, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
